// File: rtl/ppu_bg_pixel_fifo.sv
// Background pixel FIFO: 8-pixel tile-row pushes, single-pixel pops, with fine-X discard after line start.
// Optional palette lookup through bgp when PPU_BG_PALETTE_EN is defined.
module ppu_bg_pixel_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BPP   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       line_start,
  input  logic [2:0]                 fine_x,
  input  logic [7:0]                 row_lo,
  input  logic [7:0]                 row_hi,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [7:0]                 bgp,
  output logic [BPP-1:0]             px_out,
  output logic                       px_valid,
  input  logic                       px_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [BPP-1:0] mem [DEPTH];
  logic [PW-1:0]  rd_ptr, rd_ptr_nxt;
  logic [PW-1:0]  wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     disc, disc_nxt;
  logic [0:0]     state, state_nxt;
  logic           push;
  logic           head_adv;
  logic [BPP-1:0] head;

  // load_ready looks only at the registered occupancy, so a same-cycle pop never opens room
  assign load_ready = (cnt <= CW'(DEPTH - 8));
  assign px_valid   = (cnt != '0) && (disc == 3'd0);
  assign count      = cnt;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      disc   <= 3'd0;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      disc   <= disc_nxt;
      cnt    <= cnt_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
    end
  end

  // Next-state: line_start overrides everything; discard drops head pixels before any pop
  always_comb begin
    state_nxt  = state;
    disc_nxt   = disc;
    cnt_nxt    = cnt;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    push       = 1'b0;
    head_adv   = 1'b0;
    if (line_start) begin
      cnt_nxt    = '0;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      disc_nxt   = fine_x;
      state_nxt  = (fine_x != 3'd0) ? ST_DISCARD : ST_IDLE;
    end else begin
      push = load_valid && load_ready;
      case (state)
        ST_DISCARD: begin
          if (disc == 3'd0) begin
            state_nxt = ST_IDLE;
          end else if (cnt != '0) begin
            head_adv = 1'b1;
            disc_nxt = disc - 3'd1;
            if (disc == 3'd1) state_nxt = ST_IDLE;
          end
        end
        default: head_adv = px_valid && px_ready;
      endcase
      // wr_ptr always sits on an 8-entry boundary, so a row never straddles the wrap
      if (push) wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 8)) ? '0 : wr_ptr + PW'(8);
      if (head_adv) rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      cnt_nxt = cnt + (push ? CW'(8) : CW'(0)) - (head_adv ? CW'(1) : CW'(0));
    end
  end

  // Leftmost pixel (bit 7 of each plane) lands at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 8; i++) begin
        mem[wr_ptr + PW'(i)] <= {row_hi[7-i], row_lo[7-i]};
      end
    end
  end

`ifdef PPU_BG_PALETTE_EN
  always_comb begin
    px_out = '0;
    if (px_valid) px_out = bgp[{head, 1'b0} +: 2];
  end
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;

  always_comb begin
    px_out = '0;
    if (px_valid) px_out = head;
  end
`endif

endmodule

// File: doc/ppu_bg_pixel_fifo.md
PPU_BG_PIXEL_FIFO -- requirements
Module: ppu_bg_pixel_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO capacity in pixels; legal values are multiples of 8 and at least 16.
REQ-002 SHALL have parameter BPP, default 2, bits per pixel; the only legal value is 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port line_start, input, 1 bit: flush the FIFO and arm fine-scroll discard.
REQ-006 SHALL have port fine_x, input, 3 bits: SCX[2:0], sampled when line_start=1.
REQ-007 SHALL have port row_lo / row_hi, input, 8 bits each: tile-row bitplanes 0 and 1.
REQ-008 SHALL have port load_valid, input, 1 bit, and port load_ready, output, 1 bit: 8-pixel row push handshake.
REQ-009 SHALL have port bgp, input, 8 bits: background palette register value.
REQ-010 SHALL have port px_out, output, BPP bits: the pixel at the FIFO head.
REQ-011 SHALL have port px_valid, output, 1 bit, and port px_ready, input, 1 bit: pixel pop handshake.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.

Function
REQ-013 SHALL accept a row only when load_valid and load_ready are both 1 in the same cycle, writing 8 entries at the write pointer.
- Entry i = {row_hi[7-i], row_lo[7-i]}; MSB is the leftmost pixel.
REQ-014 SHALL drive load_ready = (count <= DEPTH-8) from registered count only; a same-cycle pop SHALL NOT raise load_ready.
REQ-015 SHALL pop one entry when px_valid and px_ready are both 1; px_valid = (count != 0) and discard counter == 0.
REQ-016 SHALL make pushed pixels visible on px_out/px_valid the cycle after acceptance (1-cycle latency).
REQ-017 SHALL, on a simultaneous push and pop, update count by +7 and advance both pointers.
REQ-018 SHALL wrap both pointers modulo DEPTH.
REQ-019 SHALL, on line_start, clear count and both pointers, drop any same-cycle push or pop, and load discard counter = fine_x.
- line_start has priority over all other events.
REQ-020 SHALL, while discard counter != 0 and count != 0, drop one head pixel per cycle with px_valid=0 and decrement the counter.
REQ-021 SHALL implement discard states IDLE/DISCARD: IDLE->DISCARD on line_start with fine_x != 0; DISCARD->IDLE when the counter reaches 0.
REQ-022 SHALL hold px_out at 0 whenever px_valid=0.
REQ-023 SHALL treat px_ready=1 with px_valid=0 as a no-op, with no underflow.

Reset
REQ-024 SHALL, on rst, asynchronously clear pointers, count, and discard counter, and set state IDLE.
REQ-025 SHALL, during and after rst, drive count=0, px_valid=0, px_out=0, load_ready=1.
REQ-026 SHALL abandon any in-flight row on rst mid-operation; no partial row is retained.

Configuration
REQ-027 SHALL support macro PPU_BG_PALETTE_EN.
- Defined: px_out = bgp[2*idx+1 : 2*idx], where idx is the head colour index.
- Undefined: px_out = raw colour index and bgp is ignored.

Verification
REQ-028 Reset then push row_lo=8'hF0, row_hi=8'h0F, with px_ready held 1 -> next 8 cycles px_out = 1,1,1,1,2,2,2,2 (palette off); count returns to 0.
REQ-029 DEPTH=16, px_ready=0, push two rows -> load_ready=0 at count=16; a third load_valid is not accepted; pop one pixel -> load_ready still 0 (count 15).
REQ-030 line_start with fine_x=3, push row_lo=8'hAA, row_hi=0 -> 3 cycles px_valid=0, then px_out = 0,1,0,1,0 (5 pixels).
REQ-031 Palette on, bgp=8'hE4, push row_lo=8'hFF, row_hi=8'hFF -> px_out=3 for 8 pixels; with bgp=8'h1B -> px_out=0.
REQ-032 Assert rst for 1 cycle mid-stream with count=10 -> count=0 and px_valid=0 immediately; the next pushed row is output intact.
REQ-033 With count=8, assert push and pop in the same cycle -> count=15 and the pixel order is preserved across the pointer wrap.
